// File: rtl/fight_combat_ctrl.sv
// fight_combat_ctrl: frame-synchronous combat controller for the two-player fighting top.
// Per-player kick FSMs, once-per-attack hit registration from pixel-level overlap,
// saturating health and KO/round sequencing. All timing is counted in frames.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous reset, active low
//   frame_tick   1-cycle pulse at the frame boundary; all frame state advances on it
//   video_on     high during the visible area
//   kick_btn     [0]=p1, [1]=p2 kick switches (already synchronised)
//   p1_hurt      p2 kick box overlaps p1 sprite at the current pixel
//   p2_hurt      p1 kick box overlaps p2 sprite at the current pixel
//   p1_health    p1 health (health-bar width)
//   p2_health    p2 health
//   kick_active  kick hitbox enable per player
//   hit_flash    [n]=player n+1 was damaged in the previous frame
//   round_over   high while in KO
//   winner       01=p1, 10=p2, 11=draw, 00=none; valid while round_over
//   round_rst    1-cycle pulse at round restart
module fight_combat_ctrl #(
    parameter int unsigned HEALTH_W       = 10,
    parameter int unsigned MAX_HEALTH     = 300,
    parameter int unsigned KICK_DMG       = 100,
    parameter int unsigned ACTIVE_FRAMES  = 4,
    parameter int unsigned RECOVER_FRAMES = 12,
    parameter int unsigned KO_HOLD_FRAMES = 120
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                video_on,
    input  logic [1:0]          kick_btn,
    input  logic                p1_hurt,
    input  logic                p2_hurt,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [1:0]          kick_active,
    output logic [1:0]          hit_flash,
    output logic                round_over,
    output logic [1:0]          winner,
    output logic                round_rst
);

    localparam int unsigned ATK_MAX    = (ACTIVE_FRAMES > RECOVER_FRAMES) ? ACTIVE_FRAMES
                                                                          : RECOVER_FRAMES;
    localparam int unsigned ATK_CNT_W  = (ATK_MAX > 1) ? $clog2(ATK_MAX) : 1;
    localparam int unsigned KO_CNT_W   = (KO_HOLD_FRAMES > 1) ? $clog2(KO_HOLD_FRAMES) : 1;

    localparam logic [HEALTH_W-1:0]  HP_FULL  = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0]  HP_DMG   = HEALTH_W'(KICK_DMG);
    localparam logic [ATK_CNT_W-1:0] ACT_LAST = ATK_CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [ATK_CNT_W-1:0] REC_LAST = ATK_CNT_W'(RECOVER_FRAMES - 1);
    localparam logic [KO_CNT_W-1:0]  KO_LAST  = KO_CNT_W'(KO_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {ATK_IDLE, ATK_ACTIVE, ATK_RECOVER} atk_state_t;
    typedef enum logic       {RND_FIGHT, RND_KO} rnd_state_t;

    atk_state_t           atk_state     [2];
    atk_state_t           atk_state_nxt [2];
    logic [ATK_CNT_W-1:0] atk_cnt       [2];
    logic [ATK_CNT_W-1:0] atk_cnt_nxt   [2];
    rnd_state_t           rnd_state, rnd_state_nxt;
    logic [KO_CNT_W-1:0]  ko_cnt, ko_cnt_nxt;

    logic [1:0]          prev_btn, prev_btn_nxt;
    logic [1:0]          hit_done, hit_done_nxt;     // indexed by attacker
    logic [1:0]          hurt_latch, hurt_latch_nxt; // indexed by victim
    logic [1:0]          hurt_set;
    logic [1:0]          dmg_on;                     // victim damaged at this tick
    logic [1:0]          dmg_by;                     // attacker landed at this tick
    logic [HEALTH_W-1:0] p1_health_nxt, p2_health_nxt;
    logic [1:0]          kick_active_nxt, hit_flash_nxt, winner_nxt;
    logic                round_over_nxt, round_rst_nxt;

    function automatic logic [HEALTH_W-1:0] sub_sat(input logic [HEALTH_W-1:0] h);
        return (h > HP_DMG) ? h - HP_DMG : '0;
    endfunction

    // Victim 0 (p1) is hit by attacker 1 (p2) and vice versa.
    assign hurt_set[0] = p1_hurt & video_on & kick_active[1];
    assign hurt_set[1] = p2_hurt & video_on & kick_active[0];
    assign dmg_on[0]   = hurt_latch[0] & ~hit_done[1] & (rnd_state == RND_FIGHT);
    assign dmg_on[1]   = hurt_latch[1] & ~hit_done[0] & (rnd_state == RND_FIGHT);
    assign dmg_by      = {dmg_on[0], dmg_on[1]};

    // Next-state and output logic
    always_comb begin
        atk_state_nxt  = atk_state;
        atk_cnt_nxt    = atk_cnt;
        rnd_state_nxt  = rnd_state;
        ko_cnt_nxt     = ko_cnt;
        prev_btn_nxt   = prev_btn;
        hit_done_nxt   = hit_done;
        p1_health_nxt  = p1_health;
        p2_health_nxt  = p2_health;
        hit_flash_nxt  = hit_flash;
        winner_nxt     = winner;
        round_rst_nxt  = 1'b0;
        // The latch commits on the tick; a hurt on the tick cycle seeds the new frame.
        hurt_latch_nxt = frame_tick ? hurt_set : (hurt_latch | hurt_set);

        if (frame_tick) begin
            prev_btn_nxt  = kick_btn;
            hit_flash_nxt = dmg_on;
            unique case (rnd_state)
                RND_FIGHT: begin
                    if (dmg_on[0]) p1_health_nxt = sub_sat(p1_health);
                    if (dmg_on[1]) p2_health_nxt = sub_sat(p2_health);
                    hit_done_nxt = hit_done | dmg_by;

                    for (int a = 0; a < 2; a++) begin
                        unique case (atk_state[a])
                            ATK_IDLE: begin
                                if (kick_btn[a] && !prev_btn[a]) begin
                                    atk_state_nxt[a] = ATK_ACTIVE;
                                    atk_cnt_nxt[a]   = '0;
                                    hit_done_nxt[a]  = 1'b0;
                                end
                            end
                            ATK_ACTIVE: begin
                                if (atk_cnt[a] == ACT_LAST) begin
                                    atk_state_nxt[a] = (RECOVER_FRAMES == 0) ? ATK_IDLE
                                                                             : ATK_RECOVER;
                                    atk_cnt_nxt[a]   = '0;
                                end else begin
                                    atk_cnt_nxt[a] = atk_cnt[a] + ATK_CNT_W'(1);
                                end
                            end
                            ATK_RECOVER: begin
                                if (atk_cnt[a] == REC_LAST) begin
                                    atk_state_nxt[a] = ATK_IDLE;
                                    atk_cnt_nxt[a]   = '0;
                                end else begin
                                    atk_cnt_nxt[a] = atk_cnt[a] + ATK_CNT_W'(1);
                                end
                            end
                            default: begin
                                atk_state_nxt[a] = ATK_IDLE;
                                atk_cnt_nxt[a]   = '0;
                            end
                        endcase
                    end

                    // KO entry also kills any attack in flight on the same edge.
                    if ((p1_health_nxt == '0) || (p2_health_nxt == '0)) begin
                        rnd_state_nxt = RND_KO;
                        ko_cnt_nxt    = '0;
                        winner_nxt    = {p1_health_nxt == '0, p2_health_nxt == '0};
                        for (int a = 0; a < 2; a++) begin
                            atk_state_nxt[a] = ATK_IDLE;
                            atk_cnt_nxt[a]   = '0;
                        end
                    end
                end
                RND_KO: begin
                    if (ko_cnt == KO_LAST) begin
                        rnd_state_nxt = RND_FIGHT;
                        ko_cnt_nxt    = '0;
                        p1_health_nxt = HP_FULL;
                        p2_health_nxt = HP_FULL;
                        winner_nxt    = 2'b00;
                        hit_done_nxt  = 2'b00;
                        round_rst_nxt = 1'b1;
                    end else begin
                        ko_cnt_nxt = ko_cnt + KO_CNT_W'(1);
                    end
                end
                default: rnd_state_nxt = RND_FIGHT;
            endcase
        end

        for (int a = 0; a < 2; a++) begin
            kick_active_nxt[a] = (atk_state_nxt[a] == ATK_ACTIVE);
        end
        round_over_nxt = (rnd_state_nxt == RND_KO);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            atk_state   <= '{ATK_IDLE, ATK_IDLE};
            atk_cnt     <= '{'0, '0};
            rnd_state   <= RND_FIGHT;
            ko_cnt      <= '0;
            prev_btn    <= 2'b00;
            hit_done    <= 2'b00;
            hurt_latch  <= 2'b00;
            p1_health   <= HP_FULL;
            p2_health   <= HP_FULL;
            kick_active <= 2'b00;
            hit_flash   <= 2'b00;
            round_over  <= 1'b0;
            winner      <= 2'b00;
            round_rst   <= 1'b0;
        end else begin
            atk_state   <= atk_state_nxt;
            atk_cnt     <= atk_cnt_nxt;
            rnd_state   <= rnd_state_nxt;
            ko_cnt      <= ko_cnt_nxt;
            prev_btn    <= prev_btn_nxt;
            hit_done    <= hit_done_nxt;
            hurt_latch  <= hurt_latch_nxt;
            p1_health   <= p1_health_nxt;
            p2_health   <= p2_health_nxt;
            kick_active <= kick_active_nxt;
            hit_flash   <= hit_flash_nxt;
            round_over  <= round_over_nxt;
            winner      <= winner_nxt;
            round_rst   <= round_rst_nxt;
        end
    end

endmodule

// File: tb/tb_fight_combat_ctrl.sv
// Directed bench for fight_combat_ctrl: per-frame expected snapshots go into a scoreboard
// queue when a frame is driven and are popped and compared right after its frame_tick edge.
module tb_fight_combat_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       video_on;
    logic [1:0] kick_btn;
    logic       p1_hurt;
    logic       p2_hurt;
    logic [9:0] p1_health;
    logic [9:0] p2_health;
    logic [1:0] kick_active;
    logic [1:0] hit_flash;
    logic       round_over;
    logic [1:0] winner;
    logic       round_rst;

    fight_combat_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .video_on    (video_on),
        .kick_btn    (kick_btn),
        .p1_hurt     (p1_hurt),
        .p2_hurt     (p2_hurt),
        .p1_health   (p1_health),
        .p2_health   (p2_health),
        .kick_active (kick_active),
        .hit_flash   (hit_flash),
        .round_over  (round_over),
        .winner      (winner),
        .round_rst   (round_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] p1;
        logic [9:0] p2;
        logic [1:0] ka;
        logic [1:0] hf;
        logic       ro;
        logic [1:0] win;
        logic       rr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Expected output state, maintained by the directed steps below.
    logic [9:0] e_p1, e_p2;
    logic [1:0] e_ka, e_hf, e_win;
    logic       e_ro, e_rr;
    int         ko_age;

    function automatic logic [9:0] hit(input logic [9:0] h);
        return (h > 10'd100) ? h - 10'd100 : 10'd0;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic set_reset_exp();
        e_p1 = 10'd300; e_p2 = 10'd300;
        e_ka = 2'b00; e_hf = 2'b00; e_win = 2'b00;
        e_ro = 1'b0; e_rr = 1'b0;
        ko_age = 0;
    endtask

    task automatic push_exp(input string tag);
        exp_t x;
        x.tag = tag; x.p1 = e_p1; x.p2 = e_p2; x.ka = e_ka; x.hf = e_hf;
        x.ro = e_ro; x.win = e_win; x.rr = e_rr;
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            x = sb.pop_front();
            cmp({x.tag, ".p1_health"},   16'(p1_health),   16'(x.p1));
            cmp({x.tag, ".p2_health"},   16'(p2_health),   16'(x.p2));
            cmp({x.tag, ".kick_active"}, 16'(kick_active), 16'(x.ka));
            cmp({x.tag, ".hit_flash"},   16'(hit_flash),   16'(x.hf));
            cmp({x.tag, ".round_over"},  16'(round_over),  16'(x.ro));
            cmp({x.tag, ".winner"},      16'(winner),      16'(x.win));
            cmp({x.tag, ".round_rst"},   16'(round_rst),   16'(x.rr));
        end
    endtask

    // One 4-cycle frame: overlap pulses on the three non-tick cycles (h*), optional
    // overlap on the tick cycle itself (t*); outputs checked right after the tick edge.
    task automatic frame(input logic [1:0] btn, input logic h1, input logic h2,
                         input logic t1, input logic t2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) cmp("round_rst_low", 16'(round_rst), 16'd0);
            kick_btn   = btn;
            frame_tick = 1'b0;
            video_on   = (c != 0);
            p1_hurt    = h1;
            p2_hurt    = h2;
        end
        @(negedge clk);
        frame_tick = 1'b1;
        video_on   = 1'b1;
        p1_hurt    = t1;
        p2_hurt    = t2;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        p1_hurt    = 1'b0;
        p2_hurt    = 1'b0;
        check_pop();
    endtask

    task automatic age_ko();
        ko_age++;
        e_ka = 2'b00;
        if (ko_age == 120) begin
            e_ro  = 1'b0;
            e_win = 2'b00;
            e_p1  = 10'd300;
            e_p2  = 10'd300;
            e_rr  = 1'b1;
        end
    endtask

    task automatic idle_frames(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            e_rr = 1'b0;
            e_hf = 2'b00;
            if (e_ro) age_ko();
            push_exp($sformatf("%s%0d", tag, i));
            frame(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Full attack cycle (press, 4 active, 12 recover) for the players in who.
    // land[a]: attacker a's victim overlaps during active frames; tick_only moves the
    // single overlap onto the tick cycle of the first active frame.
    task automatic kick(input logic [1:0] who, input logic [1:0] land, input bit tick_only,
                        input string tag);
        int         dmg_i;
        logic [1:0] live;
        logic       h1, h2, t1, t2, d0, d1;
        dmg_i = tick_only ? 2 : 1;
        live  = e_ro ? 2'b00 : who;
        for (int i = 0; i < 17; i++) begin
            h1 = (!tick_only && i >= 1 && i <= 4) ? land[1] : 1'b0;
            h2 = (!tick_only && i >= 1 && i <= 4) ? land[0] : 1'b0;
            t1 = (tick_only && i == 1) ? land[1] : 1'b0;
            t2 = (tick_only && i == 1) ? land[0] : 1'b0;
            e_rr = 1'b0;
            e_hf = 2'b00;
            if (e_ro) begin
                age_ko();
                live = 2'b00;
            end else begin
                if (i == dmg_i) begin
                    d0 = live[0] & land[0];
                    d1 = live[1] & land[1];
                    if (d0) e_p2 = hit(e_p2);
                    if (d1) e_p1 = hit(e_p1);
                    e_hf = {d0, d1};
                    if (e_p1 == 10'd0 || e_p2 == 10'd0) begin
                        e_ro   = 1'b1;
                        e_win  = {e_p1 == 10'd0, e_p2 == 10'd0};
                        ko_age = 0;
                        live   = 2'b00;
                    end
                end
                e_ka = (i <= 3) ? live : 2'b00;
            end
            push_exp($sformatf("%s_f%0d", tag, i));
            frame((i == 0) ? who : 2'b00, h1, h2, t1, t2);
        end
    endtask

    // One-clock reset pulse with outputs checked on the edge that samples it.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        kick_btn   = 2'b00;
        video_on   = 1'b0;
        p1_hurt    = 1'b0;
        p2_hurt    = 1'b0;
        @(posedge clk);
        #1;
        set_reset_exp();
        push_exp(tag);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        video_on   = 1'b0;
        kick_btn   = 2'b00;
        p1_hurt    = 1'b0;
        p2_hurt    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_reset_exp();
        push_exp("reset");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle frames leave everything at reset values.
        idle_frames(10, "idle");

        // Held button: one 4-frame active window, 12 recover, never retriggers.
        for (int i = 0; i < 20; i++) begin
            e_ka = (i < 4) ? 2'b01 : 2'b00;
            push_exp($sformatf("hold%0d", i));
            frame(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle_frames(1, "release");
        kick(2'b01, 2'b00, 1'b0, "repress");

        // Landing kicks: one hit per attack, then KO with p1 winning.
        kick(2'b01, 2'b01, 1'b0, "k1");
        kick(2'b01, 2'b01, 1'b0, "k2");
        kick(2'b01, 2'b01, 1'b0, "k3");
        kick(2'b01, 2'b01, 1'b0, "k4_ko");
        idle_frames(100, "ko_hold");

        // Simultaneous hits bring both to zero on one tick: draw.
        kick(2'b11, 2'b11, 1'b0, "d1");
        kick(2'b11, 2'b11, 1'b0, "d2");
        kick(2'b11, 2'b11, 1'b0, "d3");
        idle_frames(3, "draw_ko");
        reset_pulse("rst_in_ko");

        // Overlap only on the tick cycle counts in the following frame.
        kick(2'b01, 2'b01, 1'b1, "tick_hurt");

        // Reset in the middle of an active kick.
        e_ka = 2'b01;
        push_exp("pre_rst_act");
        frame(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_pulse("rst_in_active");
        idle_frames(2, "post_rst");

        cmp("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
